// File: rtl/register_universal_if.sv
// Bus bundle for register_universal: operation inputs and register/flag outputs.
// Master drives the operation; slave (the register) returns contents and flags.
interface register_universal_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] DATA;
  logic [WIDTH-1:0] A;
  logic             WE;
  logic [2:0]       MODE;
  logic             SIN;
  logic             SOUT;
  logic             CARRY;
  logic             ZERO;

  modport master (
    output DATA, WE, MODE, SIN,
    input  A, SOUT, CARRY, ZERO
  );

  modport slave (
    input  DATA, WE, MODE, SIN,
    output A, SOUT, CARRY, ZERO
  );
endinterface

// File: rtl/register_universal.sv
// Multi-mode register: hold/load/shift/rotate/inc/dec with carry and zero flags.
// Latency: one cycle from operation to A/CARRY; SOUT/ZERO combinational from A.
// Backpressure: none; accepts an operation every cycle. Option: REGISTER_UNIVERSAL_SAT_EN (saturating INC/DEC).
module register_universal #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  register_universal_if.slave bus
);
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_nxt;
  logic             carry_q;
  logic             carry_nxt;
  logic             a_max;
  logic             a_min;

  assign a_max = &a_q;
  assign a_min = ~|a_q;

  // Each mode only reads the inputs it needs, so X on unused inputs stays out of state.
  always_comb begin
    a_nxt     = a_q;
    carry_nxt = carry_q;
    if (bus.WE) begin
      case (bus.MODE)
        MODE_HOLD: begin
          a_nxt     = a_q;
          carry_nxt = carry_q;
        end
        MODE_LOAD: begin
          a_nxt     = bus.DATA;
          carry_nxt = 1'b0;
        end
        MODE_SHL: begin
          a_nxt     = {a_q[WIDTH-2:0], bus.SIN};
          carry_nxt = a_q[WIDTH-1];
        end
        MODE_SHR: begin
          a_nxt     = {bus.SIN, a_q[WIDTH-1:1]};
          carry_nxt = a_q[0];
        end
        MODE_ROL: begin
          a_nxt     = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
          carry_nxt = a_q[WIDTH-1];
        end
        MODE_ROR: begin
          a_nxt     = {a_q[0], a_q[WIDTH-1:1]};
          carry_nxt = a_q[0];
        end
        MODE_INC: begin
          carry_nxt = a_max;
`ifdef REGISTER_UNIVERSAL_SAT_EN
          a_nxt     = a_max ? a_q : a_q + WIDTH'(1);
`else
          a_nxt     = a_q + WIDTH'(1);
`endif
        end
        MODE_DEC: begin
          carry_nxt = a_min;
`ifdef REGISTER_UNIVERSAL_SAT_EN
          a_nxt     = a_min ? a_q : a_q - WIDTH'(1);
`else
          a_nxt     = a_q - WIDTH'(1);
`endif
        end
        default: begin
          a_nxt     = a_q;
          carry_nxt = carry_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_nxt;
      carry_q <= carry_nxt;
    end
  end

  assign bus.A     = a_q;
  assign bus.CARRY = carry_q;
  assign bus.SOUT  = a_q[WIDTH-1];
  assign bus.ZERO  = (a_q == '0);
endmodule

// File: tb/tb_register_universal.sv
// Scoreboard bench for register_universal (WIDTH=4): reference model predicts each
// edge, expected values are queued at drive time and popped after the edge.
module tb_register_universal;
  logic clk;
  logic reset;

  register_universal_if #(.WIDTH(4)) bus ();

  register_universal #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic       c;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_a;
  logic       m_c;
  int         total;
  int         bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour written in integer arithmetic.
  task automatic model(input logic r, input logic we, input logic [2:0] mode,
                       input logic [3:0] data, input logic sin);
    int v;
    if (r) begin
      m_a = 4'd0;
      m_c = 1'b0;
    end else if (we) begin
      case (mode)
        3'd1: begin m_a = data; m_c = 1'b0; end
        3'd2: begin m_c = m_a[3]; m_a = {m_a[2:0], sin}; end
        3'd3: begin m_c = m_a[0]; m_a = {sin, m_a[3:1]}; end
        3'd4: begin m_c = m_a[3]; m_a = {m_a[2:0], m_a[3]}; end
        3'd5: begin m_c = m_a[0]; m_a = {m_a[0], m_a[3:1]}; end
        3'd6: begin
          v = int'(m_a) + 1;
          if (v == 16) begin
            m_c = 1'b1;
`ifdef REGISTER_UNIVERSAL_SAT_EN
            m_a = 4'd15;
`else
            m_a = 4'd0;
`endif
          end else begin
            m_c = 1'b0;
            m_a = v[3:0];
          end
        end
        3'd7: begin
          v = int'(m_a) - 1;
          if (v < 0) begin
            m_c = 1'b1;
`ifdef REGISTER_UNIVERSAL_SAT_EN
            m_a = 4'd0;
`else
            m_a = 4'd15;
`endif
          end else begin
            m_c = 1'b0;
            m_a = v[3:0];
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic r, input logic we, input logic [2:0] mode,
                      input logic [3:0] data, input logic sin);
    exp_t e;
    reset    = r;
    bus.WE   = we;
    bus.MODE = mode;
    bus.DATA = data;
    bus.SIN  = sin;
    model(r, we, mode, data, sin);
    e.a = m_a;
    e.c = m_c;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_a"}, 32'(bus.A), 32'(e.a));
      chk({tag, "_carry"}, 32'(bus.CARRY), 32'(e.c));
      chk({tag, "_zero"}, 32'(bus.ZERO), 32'(e.a == 4'd0));
      chk({tag, "_sout"}, 32'(bus.SOUT), 32'(e.a[3]));
    end
  endtask

  logic       c_saved;
  logic [2:0] gate_modes[3];

  initial begin
    total = 0;
    bad   = 0;
    m_a   = 4'd0;
    m_c   = 1'b0;
    reset    = 1'b1;
    bus.WE   = 1'b0;
    bus.MODE = 3'd0;
    bus.DATA = 4'd0;
    bus.SIN  = 1'b0;
    gate_modes[0] = 3'b001;
    gate_modes[1] = 3'b010;
    gate_modes[2] = 3'b110;
    @(negedge clk);

    // Reset then load
    step("rst", 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    chk("rst_a_lit", 32'(bus.A), 32'h0);
    chk("rst_zero_lit", 32'(bus.ZERO), 32'h1);
    step("load", 1'b0, 1'b1, 3'b001, 4'b1010, 1'b0);
    chk("load_a_lit", 32'(bus.A), 32'hA);

    // Enable gating
    step("shl_pre", 1'b0, 1'b1, 3'b010, 4'd0, 1'b0);
    step("reload", 1'b0, 1'b1, 3'b001, 4'b1010, 1'b0);
    step("shl_c", 1'b0, 1'b1, 3'b100, 4'd0, 1'b0);
    c_saved = bus.CARRY;
    for (int i = 0; i < 3; i++) step("gate", 1'b0, 1'b0, gate_modes[i], 4'b0101, 1'b1);
    chk("gate_a_lit", 32'(bus.A), 32'h5);
    chk("gate_c_hold", 32'(bus.CARRY), 32'(c_saved));

    // Shifts and rotates from 1001
    step("ld1001", 1'b0, 1'b1, 3'b001, 4'b1001, 1'b0);
    step("shl", 1'b0, 1'b1, 3'b010, 4'd0, 1'b1);
    chk("shl_lit", 32'({bus.A, bus.CARRY}), 32'({4'b0011, 1'b1}));
    step("shr", 1'b0, 1'b1, 3'b011, 4'd0, 1'b0);
    chk("shr_lit", 32'({bus.A, bus.CARRY}), 32'({4'b0001, 1'b1}));
    step("ror", 1'b0, 1'b1, 3'b101, 4'd0, 1'b1);
    chk("ror_lit", 32'({bus.A, bus.CARRY}), 32'({4'b1000, 1'b1}));
    step("rol", 1'b0, 1'b1, 3'b100, 4'd0, 1'b0);
    chk("rol_lit", 32'({bus.A, bus.CARRY}), 32'({4'b0001, 1'b1}));

    // Counter boundaries
    step("ld1110", 1'b0, 1'b1, 3'b001, 4'b1110, 1'b0);
    step("inc1", 1'b0, 1'b1, 3'b110, 4'd0, 1'b0);
    chk("inc1_lit", 32'({bus.A, bus.CARRY}), 32'({4'b1111, 1'b0}));
    step("inc2", 1'b0, 1'b1, 3'b110, 4'd0, 1'b0);
`ifdef REGISTER_UNIVERSAL_SAT_EN
    chk("inc2_lit", 32'({bus.A, bus.CARRY}), 32'({4'b1111, 1'b1}));
    step("ld0", 1'b0, 1'b1, 3'b001, 4'b0000, 1'b0);
    step("dec0", 1'b0, 1'b1, 3'b111, 4'd0, 1'b0);
    chk("dec0_lit", 32'({bus.A, bus.CARRY}), 32'({4'b0000, 1'b1}));
`else
    chk("inc2_lit", 32'({bus.A, bus.CARRY, bus.ZERO}), 32'({4'b0000, 1'b1, 1'b1}));
    step("dec0", 1'b0, 1'b1, 3'b111, 4'd0, 1'b0);
    chk("dec0_lit", 32'({bus.A, bus.CARRY}), 32'({4'b1111, 1'b1}));
`endif

    // Reset mid-operation and reset priority
    step("ld0111", 1'b0, 1'b1, 3'b001, 4'b0111, 1'b0);
    step("mid_rst", 1'b1, 1'b1, 3'b110, 4'd0, 1'b0);
    chk("mid_rst_lit", 32'({bus.A, bus.CARRY}), 32'({4'b0000, 1'b0}));
    step("resume", 1'b0, 1'b1, 3'b110, 4'd0, 1'b0);
    chk("resume_lit", 32'(bus.A), 32'h1);
    step("rst_prio", 1'b1, 1'b1, 3'b001, 4'b1111, 1'b0);
    chk("rst_prio_lit", 32'(bus.A), 32'h0);

    // Random operation mix
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_universal.md
# register_universal

Parametrised multi-mode register for the single-cycle processor datapath: the successor to the plain load-enable register. Besides hold and parallel load, it performs shifts, rotates and increment/decrement with serial in/out and carry/zero flags. It is used wherever the datapath needs a scratch, shift or counter register without separate ALU logic.

## Interface

- `WIDTH`, default 4: data width in bits; legal range ≥ 2.

- `clk` input, 1: rising-edge clock.
- `reset` input, 1: synchronous, active-high; sampled on rising `clk`.
- `DATA` input, `WIDTH`: parallel load value.
- `A` output, `WIDTH`: register contents.
- `WE` input, 1: operation enable; when 0 the register holds regardless of `MODE`.
- `MODE` input, 3: operation select; see Operation.
- `SIN` input, 1: serial input bit for logical shifts.
- `SOUT` output, 1: combinational `A[WIDTH-1]`.
- `CARRY` output, 1: registered flag; the bit shifted out, or the wrap/carry/borrow from the last operation.
- `ZERO` output, 1: combinational `(A == 0)`.

## Operation

- Priority on each rising `clk`: `reset` first, then `WE`, then `MODE`.
- `reset`=1 sets `A` to 0 and `CARRY` to 0. `ZERO` is then 1 and `SOUT` is 0. `WE`, `MODE` and `DATA` are ignored.
- `WE`=0: `A` and `CARRY` hold.
- `WE`=1, by `MODE`:
  - 000 HOLD: `A` holds; `CARRY` holds.
  - 001 LOAD: `A` takes `DATA`; `CARRY` is cleared to 0.
  - 010 SHL: `A` takes `{A[WIDTH-2:0], SIN}`; `CARRY` takes the old `A[WIDTH-1]`.
  - 011 SHR: `A` takes `{SIN, A[WIDTH-1:1]}`; `CARRY` takes the old `A[0]`.
  - 100 ROL: `A` takes `{A[WIDTH-2:0], A[WIDTH-1]}`; `CARRY` takes the old `A[WIDTH-1]`.
  - 101 ROR: `A` takes `{A[0], A[WIDTH-1:1]}`; `CARRY` takes the old `A[0]`.
  - 110 INC: `A` takes `A+1` modulo 2^WIDTH. `CARRY` is 1 only when the old `A` was all-ones, otherwise 0.
  - 111 DEC: `A` takes `A-1` modulo 2^WIDTH. `CARRY` is 1 only when the old `A` was 0 (borrow), otherwise 0.
- Arithmetic is unsigned.
- `CARRY` always reflects the most recent enabled non-HOLD operation, or reset.
- `SIN` is used only by SHL and SHR; it is ignored by every other mode.
- Inputs are don't-care when unused. X on an unused input must not propagate into `A` or `CARRY`.

## Timing

- The block has a single clock domain. All state changes on the rising edge of `clk`.
- Latency is one cycle: an operation applied before edge N is visible on `A` and `CARRY` after edge N.
- `SOUT` and `ZERO` are combinational from `A`. They settle in the same cycle `A` updates and carry no added latency.
- Back-to-back operations are allowed every cycle. A shift chain of k cycles gives k bit positions of shift.
- Reset asserted mid-sequence takes effect at the next edge and abandons any operation presented in that cycle.
- Operation resumes on the first edge after `reset` is sampled low.
- No input registers and no handshake. The caller holds `MODE`, `DATA` and `SIN` stable across the setup window.

## Configuration

- Macro: `REGISTER_UNIVERSAL_SAT_EN`.
- Defined: INC and DEC saturate.
  - INC at all-ones leaves `A` unchanged and sets `CARRY`=1.
  - DEC at 0 leaves `A` unchanged and sets `CARRY`=1.
  - All other modes are unaffected.
- Undefined (default): INC and DEC wrap modulo 2^WIDTH as described in Operation.
- `CARRY` semantics are identical in both builds: 1 exactly when the boundary was hit.

## Test plan

All scenarios use `WIDTH`=4.

1. Reset then load: `reset`=1 for one edge gives `A`=0000, `CARRY`=0, `ZERO`=1. Then `WE`=1, `MODE`=001, `DATA`=1010 gives `A`=1010, `ZERO`=0, `SOUT`=1.
2. Enable gating: with `A`=1010, `WE`=0 for 3 cycles with `MODE` cycling 001/010/110 and `DATA`=0101 leaves `A`=1010 and `CARRY` unchanged.
3. Shifts and rotates from `A`=1001:
   - SHL with `SIN`=1 gives `A`=0011, `CARRY`=1.
   - Then SHR with `SIN`=0 gives `A`=0001, `CARRY`=1.
   - Then ROR gives `A`=1000, `CARRY`=1.
   - Then ROL gives `A`=0001, `CARRY`=1.
4. Counter boundaries:
   - Load 1110, then INC twice gives 1111 (`CARRY`=0), then 0000 (`CARRY`=1, `ZERO`=1).
   - Then DEC gives 1111 (`CARRY`=1).
   - With `REGISTER_UNIVERSAL_SAT_EN`, the same sequence gives 1111 then 1111 (`CARRY`=1). After reloading 0000, DEC holds at 0000 with `CARRY`=1.
5. Reset mid-operation: `A`=0111 with `MODE`=110 and `WE`=1 every cycle. Assert `reset` on one edge: `A`=0000 and `CARRY`=0 at that edge, not 1000. INC resumes on the next edge to give 0001.
6. Reset priority: `reset`=1 together with `WE`=1, `MODE`=001, `DATA`=1111 gives `A`=0000.
